// File: rtl/vga_anim_pkg.sv
// Shared types and constants for the VGA animation scene scheduler.
package vga_anim_pkg;

  typedef enum logic [1:0] {
    PLAY     = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2
  } anim_state_t;

  typedef enum logic {
    DIR_PLUS  = 1'b0,
    DIR_MINUS = 1'b1
  } anim_dir_t;

  localparam logic [7:0] FULL_BRIGHT = 8'd255;

endpackage

// File: rtl/anim_dwell_timer.sv
// Counts one-second ticks towards the scene dwell time and pulses on expiry.
module anim_dwell_timer #(
  parameter int SCENE_SECS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_enable,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_expire
);

  localparam int CW = (SCENE_SECS > 1) ? $clog2(SCENE_SECS) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCENE_SECS - 1);

  logic [CW-1:0] r_count;
  logic          w_hit;

  assign w_hit    = i_enable & i_tick & (r_count == LAST);
  assign o_expire = w_hit & ~i_clear;

  // Count enabled ticks, wrapping to zero on the terminal tick; clear wins
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && i_tick) begin
      r_count <= w_hit ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_anim_sched.sv
// Scene scheduler: dwell-timed / user-driven scene changes wrapped in a
// frame-stepped fade-out and fade-in, with a pause flag and 1-deep request slot.
module vga_anim_sched
  import vga_anim_pkg::*;
#(
  parameter int NUM_SCENES  = 4,
  parameter int SCENE_SECS  = 8,
  parameter int FADE_FRAMES = 16
) (
  input  logic                          pixel_clk,
  input  logic                          rst,
  input  logic                          frame_tick,
  input  logic                          tick_1s_pix,
  input  logic                          auto_en,
  input  logic                          req_next,
  input  logic                          req_prev,
  input  logic                          req_pause,
  output logic [$clog2(NUM_SCENES)-1:0] scene,
  output logic                          scene_tick,
  output logic [7:0]                    fade_level,
  output logic                          anim_run,
  output logic                          busy,
  output logic                          paused
);

  localparam int SW   = $clog2(NUM_SCENES);
  localparam int FW   = $clog2(FADE_FRAMES) + 1;
  localparam int STEP = 256 / FADE_FRAMES;
  localparam logic [FW-1:0] FCNT_FULL  = FW'(FADE_FRAMES);
  localparam logic [FW-1:0] FCNT_ONE   = FW'(1);
  localparam logic [SW-1:0] SCENE_LAST = SW'(NUM_SCENES - 1);

  anim_state_t   r_state, w_stateNext;
  anim_dir_t     r_dir, w_dirNext;
  anim_dir_t     r_pendDir, w_pendDirNext;
  anim_dir_t     w_reqDir;
  logic [FW-1:0] r_fcnt, w_fcntNext, w_fcntInc;
  logic [SW-1:0] r_scene, w_sceneNext;
  logic          r_pendValid, w_pendValidNext;
  logic          r_paused, w_pausedNext;
  logic          r_sceneChgd, w_sceneChg;
  logic          r_sceneTick;
  logic [7:0]    r_fadeLevel, w_fadeNext;
  logic          r_busy;
  logic          r_animRun;
  logic          w_reqOk;
  logic          w_dwellClear;
  logic          w_dwellEnable;
  logic          w_expire;
  logic [31:0]   w_fadeProd;

  assign w_reqOk       = req_next ^ req_prev;
  assign w_reqDir      = req_prev ? DIR_MINUS : DIR_PLUS;
  assign w_fcntInc     = r_fcnt + 1'b1;
  assign w_dwellEnable = (r_state == PLAY) & auto_en & ~r_paused;

  anim_dwell_timer #(
    .SCENE_SECS (SCENE_SECS)
  ) u_dwell (
    .clk      (pixel_clk),
    .rst      (rst),
    .i_enable (w_dwellEnable),
    .i_clear  (w_dwellClear),
    .i_tick   (tick_1s_pix),
    .o_expire (w_expire)
  );

  // Next-state logic: fade sequencing, scene stepping, pending slot and pause
  always_comb begin
    w_stateNext     = r_state;
    w_fcntNext      = r_fcnt;
    w_sceneNext     = r_scene;
    w_dirNext       = r_dir;
    w_pendValidNext = r_pendValid;
    w_pendDirNext   = r_pendDir;
    w_pausedNext    = r_paused ^ req_pause;
    w_sceneChg      = 1'b0;
    w_dwellClear    = ~auto_en;

    case (r_state)
      PLAY: begin
        if (w_reqOk) begin
          w_stateNext     = FADE_OUT;
          w_dirNext       = w_reqDir;
          w_pendValidNext = 1'b0;
        end else if (r_pendValid) begin
          w_stateNext     = FADE_OUT;
          w_dirNext       = r_pendDir;
          w_pendValidNext = 1'b0;
        end else if (w_expire) begin
          w_stateNext = FADE_OUT;
          w_dirNext   = DIR_PLUS;
        end
      end
      FADE_OUT: begin
        if (w_reqOk) begin
          w_pendValidNext = 1'b1;
          w_pendDirNext   = w_reqDir;
        end
        if (frame_tick) begin
          w_fcntNext = r_fcnt - 1'b1;
          if (r_fcnt == FCNT_ONE) begin
            w_stateNext = FADE_IN;
            w_sceneChg  = 1'b1;
            if (r_dir == DIR_PLUS) begin
              w_sceneNext = (r_scene == SCENE_LAST) ? '0 : r_scene + 1'b1;
            end else begin
              w_sceneNext = (r_scene == '0) ? SCENE_LAST : r_scene - 1'b1;
            end
          end
        end
      end
      FADE_IN: begin
        if (w_reqOk) begin
          w_pendValidNext = 1'b1;
          w_pendDirNext   = w_reqDir;
        end
        if (frame_tick) begin
          w_fcntNext = w_fcntInc;
          if (w_fcntInc == FCNT_FULL) begin
            w_stateNext  = PLAY;
            w_dwellClear = 1'b1;
          end
        end
      end
      default: begin
        w_stateNext = PLAY;
      end
    endcase

    w_fadeProd = 32'(w_fcntNext) * 32'(STEP);
    w_fadeNext = (w_fadeProd > 32'd255) ? FULL_BRIGHT : w_fadeProd[7:0];
  end

  // State and datapath registers; outputs are registered from next values
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_state     <= PLAY;
      r_fcnt      <= FCNT_FULL;
      r_scene     <= '0;
      r_dir       <= DIR_PLUS;
      r_pendValid <= 1'b0;
      r_pendDir   <= DIR_PLUS;
      r_paused    <= 1'b0;
      r_sceneChgd <= 1'b0;
      r_sceneTick <= 1'b0;
      r_fadeLevel <= FULL_BRIGHT;
      r_busy      <= 1'b0;
      r_animRun   <= 1'b1;
    end else begin
      r_state     <= w_stateNext;
      r_fcnt      <= w_fcntNext;
      r_scene     <= w_sceneNext;
      r_dir       <= w_dirNext;
      r_pendValid <= w_pendValidNext;
      r_pendDir   <= w_pendDirNext;
      r_paused    <= w_pausedNext;
      r_sceneChgd <= w_sceneChg;
      r_sceneTick <= r_sceneChgd;
      r_fadeLevel <= w_fadeNext;
      r_busy      <= (w_stateNext != PLAY);
      r_animRun   <= ~w_pausedNext;
    end
  end

  assign scene      = r_scene;
  assign scene_tick = r_sceneTick;
  assign fade_level = r_fadeLevel;
  assign anim_run   = r_animRun;
  assign busy       = r_busy;
  assign paused     = r_paused;

endmodule

// File: tb/tb_vga_anim_sched.sv
// Directed bench for the scene scheduler with small parameters so that
// fades and dwell expiries take only a handful of pulses.
module tb_vga_anim_sched;

  logic       pixel_clk;
  logic       rst;
  logic       frame_tick;
  logic       tick_1s_pix;
  logic       auto_en;
  logic       req_next;
  logic       req_prev;
  logic       req_pause;
  logic [1:0] scene;
  logic       scene_tick;
  logic [7:0] fade_level;
  logic       anim_run;
  logic       busy;
  logic       paused;

  int checkCount = 0;
  int failCount  = 0;

  vga_anim_sched #(
    .NUM_SCENES  (4),
    .SCENE_SECS  (3),
    .FADE_FRAMES (4)
  ) dut (
    .pixel_clk   (pixel_clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .tick_1s_pix (tick_1s_pix),
    .auto_en     (auto_en),
    .req_next    (req_next),
    .req_prev    (req_prev),
    .req_pause   (req_pause),
    .scene       (scene),
    .scene_tick  (scene_tick),
    .fade_level  (fade_level),
    .anim_run    (anim_run),
    .busy        (busy),
    .paused      (paused)
  );

  // Free-running pixel clock
  initial begin
    pixel_clk = 1'b0;
    forever #5 pixel_clk = ~pixel_clk;
  end

  // Compare one observed value with its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge
  task automatic stepCycle();
    @(posedge pixel_clk);
    #1;
  endtask

  // Present a set of one-cycle pulses for exactly one clock edge
  task automatic applyStimulus(input logic tick, input logic frame,
                               input logic nxt, input logic prv,
                               input logic pse);
    tick_1s_pix = tick;
    frame_tick  = frame;
    req_next    = nxt;
    req_prev    = prv;
    req_pause   = pse;
    stepCycle();
    tick_1s_pix = 1'b0;
    frame_tick  = 1'b0;
    req_next    = 1'b0;
    req_prev    = 1'b0;
    req_pause   = 1'b0;
  endtask

  task automatic runFrames(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 1, 0, 0, 0);
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) stepCycle();
    rst = 1'b0;
  endtask

  logic [7:0] outLevels [4];
  logic [7:0] inLevels  [4];

  initial begin
    outLevels = '{8'd192, 8'd128, 8'd64, 8'd0};
    inLevels  = '{8'd64, 8'd128, 8'd192, 8'd255};
    rst = 1'b1; frame_tick = 0; tick_1s_pix = 0; auto_en = 0;
    req_next = 0; req_prev = 0; req_pause = 0;

    // Reset
    doReset(2);
    checkOutput("rst_scene", scene, 0);
    checkOutput("rst_fade", fade_level, 255);
    checkOutput("rst_run", anim_run, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_paused", paused, 0);
    checkOutput("rst_stick", scene_tick, 0);

    // Auto advance after three seconds
    auto_en = 1'b1;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("auto_not_yet", busy, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("auto_busy", busy, 1);
    checkOutput("auto_hold255", fade_level, 255);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("auto_fadeout", fade_level, outLevels[i]);
    end
    checkOutput("auto_scene", scene, 1);
    checkOutput("auto_stick_early", scene_tick, 0);
    stepCycle();
    checkOutput("auto_stick", scene_tick, 1);
    stepCycle();
    checkOutput("auto_stick_off", scene_tick, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("auto_fadein", fade_level, inLevels[i]);
    end
    checkOutput("auto_done", busy, 0);
    auto_en = 1'b0;

    // Wrap backwards from 0, then forward again
    doReset(1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("prev_busy", busy, 1);
    runFrames(4);
    checkOutput("prev_wrap", scene, 3);
    runFrames(4);
    checkOutput("prev_done", busy, 0);
    applyStimulus(0, 0, 1, 0, 0);
    runFrames(8);
    checkOutput("next_wrap", scene, 0);
    checkOutput("next_done", busy, 0);

    // Pending slot overwritten during FADE_IN
    applyStimulus(0, 0, 1, 0, 0);
    runFrames(4);
    checkOutput("pend_scene1", scene, 1);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    runFrames(4);
    checkOutput("pend_play", busy, 0);
    checkOutput("pend_full", fade_level, 255);
    stepCycle();
    checkOutput("pend_refade", busy, 1);
    runFrames(4);
    checkOutput("pend_dir_minus", scene, 0);
    runFrames(4);
    checkOutput("pend_done", busy, 0);

    // Conflicting requests, and dwell expiry colliding with req_prev
    applyStimulus(0, 1, 1, 1, 0);
    stepCycle();
    checkOutput("conf_nofade", busy, 0);
    auto_en = 1'b1;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0);
    checkOutput("conf_busy", busy, 1);
    checkOutput("conf_tick_ignored", fade_level, 255);
    runFrames(4);
    checkOutput("conf_dir_minus", scene, 3);
    runFrames(4);
    checkOutput("conf_done", busy, 0);
    auto_en = 1'b0;
    stepCycle();

    // Pause freezes the dwell count without clearing it
    auto_en = 1'b1;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("pause_run", anim_run, 0);
    checkOutput("pause_flag", paused, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("pause_frozen", busy, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("unpause_run", anim_run, 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("unpause_count2", busy, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("unpause_expire", busy, 1);
    runFrames(8);
    checkOutput("unpause_scene", scene, 0);
    auto_en = 1'b0;

    // Reset in the middle of FADE_OUT
    applyStimulus(0, 0, 0, 1, 0);
    runFrames(2);
    checkOutput("mid_fade", fade_level, 128);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("mid_paused", paused, 1);
    doReset(1);
    checkOutput("mrst_scene", scene, 0);
    checkOutput("mrst_fade", fade_level, 255);
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_paused", paused, 0);
    checkOutput("mrst_run", anim_run, 1);
    runFrames(1);
    checkOutput("mrst_play_ignores_frame", fade_level, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/vga_anim_sched.md
# vga_anim_sched

Scene scheduler for the VGA animation path. Runs in the `pixel_clk` domain and consumes the per-frame `frame_tick` and the pixel-domain one-second pulse. It sequences which animation scene is displayed: automatic dwell-timed advance, user next/prev/pause requests, and a frame-stepped fade-out/fade-in around every scene change. Outputs drive the scene mux, the pixel brightness scaler and the run-enable of the animation phase counter.

## Interface
Parameters:
- `NUM_SCENES`, 4: number of scenes, 2..16; scene index wraps modulo this value.
- `SCENE_SECS`, 8: auto-advance dwell in seconds, 1..255.
- `FADE_FRAMES`, 16: frames per fade half; power of two, 1..256.

Ports:
- `pixel_clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse per frame.
- `tick_1s_pix` in 1: one-cycle pulse per second, already in the `pixel_clk` domain.
- `auto_en` in 1: level; enables dwell-timed auto-advance.
- `req_next` in 1: one-cycle pulse requesting the next scene.
- `req_prev` in 1: one-cycle pulse requesting the previous scene.
- `req_pause` in 1: one-cycle pulse that toggles pause.
- `scene` out clog2(`NUM_SCENES`): current scene index.
- `scene_tick` out 1: one-cycle pulse after `scene` changes.
- `fade_level` out 8: brightness; 0 = black, 255 = full.
- `anim_run` out 1: enable for the animation phase counters.
- `busy` out 1: high while a fade is in progress.
- `paused` out 1: pause flag.

## Operation
- States: PLAY, FADE_OUT, FADE_IN. Reset values:
  - state = PLAY, `scene` = 0.
  - `fcnt` = `FADE_FRAMES`, `fade_level` = 255.
  - `paused` = 0, `anim_run` = 1, `busy` = 0, `scene_tick` = 0.
  - dwell counter = 0, pending request = none.
- `fade_level` = min(255, `fcnt`·(256/`FADE_FRAMES`)). `fcnt` is clog2(`FADE_FRAMES`)+1 bits wide.
- **PLAY**
  - Dwell counter increments on `tick_1s_pix` when `auto_en` and !`paused`.
  - The dwell counter is cleared while `auto_en` = 0.
  - A tick arriving while the count = `SCENE_SECS`-1 clears the count and triggers FADE_OUT with direction +1.
  - `req_next` triggers FADE_OUT with direction +1; `req_prev` triggers FADE_OUT with direction -1.
  - A user request and dwell expiry in the same cycle: the request wins.
  - A pending request is served on the first PLAY cycle as if it had just arrived.
- **FADE_OUT**
  - Each `frame_tick` decrements `fcnt`.
  - On the tick that takes `fcnt` from 1 to 0: state becomes FADE_IN and `scene` updates at the same edge (wrap NUM_SCENES-1 to 0 on +1, 0 to NUM_SCENES-1 on -1).
- **FADE_IN**
  - Each `frame_tick` increments `fcnt`.
  - On reaching `FADE_FRAMES`: state becomes PLAY and the dwell counter clears.
- **Requests during fades**
  - `req_next`/`req_prev` arriving during FADE_OUT or FADE_IN are stored in a 1-deep pending slot; a later request overwrites an earlier one.
  - `req_next` and `req_prev` in the same cycle: both ignored in every state.
- **Pause**
  - `req_pause` toggles `paused` in any state, and combines with a same-cycle next/prev.
  - Fades proceed regardless of pause.
  - `anim_run` = !`paused`.
  - Dwell counting is frozen while paused; the count is held.
- `busy` = 1 exactly when state is FADE_OUT or FADE_IN.
- `frame_tick` is ignored in PLAY.
- `rst` asserted mid-fade returns every register to its reset value at the next edge.

## Timing
- All outputs are registered.
- FADE_OUT is entered at the edge after the trigger cycle; `busy` rises with it. `fade_level` holds 255 until the first `frame_tick` in FADE_OUT.
- `fade_level` changes at the edge that samples `frame_tick`.
- `scene_tick` is high for one cycle, in the cycle after `scene` changes.
- A full scene change takes exactly 2·`FADE_FRAMES` frame_ticks.
- `anim_run` follows `req_pause` with 1 cycle of latency.
- A `frame_tick` and a trigger in the same PLAY cycle: the tick is not counted toward the new fade.

## Structure
- Shared package `vga_anim_pkg`:
  - state encoding `anim_state_t` (PLAY, FADE_OUT, FADE_IN);
  - direction encoding (+1/-1);
  - the constant 255 for full brightness.
- Sub-module `anim_dwell_timer`:
  - `tick_1s_pix` counter with enable, clear and terminal pulse, parameterised by `SCENE_SECS`.
- The FSM, fade ramp, pending slot and pause flag live in the top level.

## Test plan
Parameters for all scenarios: `NUM_SCENES`=4, `SCENE_SECS`=3, `FADE_FRAMES`=4.
- **Reset:** assert `rst` for 2 cycles. Expect `scene`=0, `fade_level`=255, `anim_run`=1, `busy`=0, `paused`=0.
- **Auto advance:** `auto_en`=1, three `tick_1s_pix` pulses. Expect FADE_OUT. Over 4 frame_ticks `fade_level` = 192, 128, 64, 0; `scene`=1 with `scene_tick` one cycle later. Over 4 more frame_ticks `fade_level` = 64, 128, 192, 255; `busy` then drops.
- **Wrap and prev:** `req_prev` at `scene`=0. Expect `scene`=3 after 4 frame_ticks. A later `req_next` returns `scene` to 0.
- **Pending overwrite:** during FADE_IN, `req_next` then `req_prev`. Expect, on return to PLAY, an immediate new fade with direction -1.
- **Conflicts:** `req_next`+`req_prev` together produce no fade. Dwell expiry + `req_prev` in the same cycle gives direction -1.
- **Pause and reset:** `req_pause` gives `anim_run`=0 next cycle; `tick_1s_pix` pulses do not advance the dwell. `rst` at `fcnt`=2 of FADE_OUT gives full reset values on the next cycle.
